// File: rtl/iomem_timer.sv
// Countdown timer with prescaler, responding on the iomem bus.
// 32-byte register window with a registered single-cycle acknowledge.
module iomem_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        enable_q, enable_d;
   logic        irq_en_q, irq_en_d;
   logic        auto_reload_q, auto_reload_d;
   logic [31:0] load_q, load_d;
   logic [31:0] count_q, count_d;
   logic        expired_q, expired_d;
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] pcnt_q, pcnt_d;

   logic        sel, accept, wr_en, tick, expire;
   logic [2:0]  reg_off;
   logic [31:0] rd_val;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^iomem_addr[1:0];

   always_comb begin
      sel     = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
      accept  = sel && !ready_q;
      wr_en   = accept && (iomem_wstrb != 4'b0000);
      reg_off = iomem_addr[4:2];
      tick    = enable_q && (pcnt_q == prescale_q);
      expire  = tick && (count_q == 32'd0);

      case (reg_off)
         3'd0:    rd_val = {29'b0, auto_reload_q, irq_en_q, enable_q};
         3'd1:    rd_val = load_q;
         3'd2:    rd_val = count_q;
         3'd3:    rd_val = {31'b0, expired_q};
         3'd4:    rd_val = {16'b0, prescale_q};
         default: rd_val = 32'd0;
      endcase

      ready_d = accept;
      rdata_d = accept ? rd_val : 32'd0;

      pcnt_d = (enable_q && !tick) ? pcnt_q + 16'd1 : 16'd0;

      // One-shot clear first so a same-cycle CTRL write overrides it
      enable_d      = enable_q;
      irq_en_d      = irq_en_q;
      auto_reload_d = auto_reload_q;
      if (expire && !auto_reload_q) enable_d = 1'b0;
      if (wr_en && reg_off == 3'd0 && iomem_wstrb[0]) begin
         enable_d      = iomem_wdata[0];
         irq_en_d      = iomem_wdata[1];
         auto_reload_d = iomem_wdata[2];
      end

      load_d = load_q;
      if (wr_en && reg_off == 3'd1) load_d = byte_merge(load_q, iomem_wdata, iomem_wstrb);

      // Bus write to COUNT takes precedence over decrement/reload
      count_d = count_q;
      if (tick) begin
         if (count_q != 32'd0)  count_d = count_q - 32'd1;
         else if (auto_reload_q) count_d = load_q;
      end
      if (wr_en && reg_off == 3'd2) count_d = byte_merge(count_q, iomem_wdata, iomem_wstrb);

      expired_d = expired_q;
      if (wr_en && reg_off == 3'd3 && iomem_wstrb[0] && iomem_wdata[0]) expired_d = 1'b0;
      if (expire) expired_d = 1'b1;

      prescale_d = prescale_q;
      if (wr_en && reg_off == 3'd4) begin
         if (iomem_wstrb[0]) prescale_d[7:0]  = iomem_wdata[7:0];
         if (iomem_wstrb[1]) prescale_d[15:8] = iomem_wdata[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q       <= 1'b0;
         rdata_q       <= 32'd0;
         enable_q      <= 1'b0;
         irq_en_q      <= 1'b0;
         auto_reload_q <= 1'b0;
         load_q        <= 32'd0;
         count_q       <= 32'd0;
         expired_q     <= 1'b0;
         prescale_q    <= 16'd0;
         pcnt_q        <= 16'd0;
      end else begin
         ready_q       <= ready_d;
         rdata_q       <= rdata_d;
         enable_q      <= enable_d;
         irq_en_q      <= irq_en_d;
         auto_reload_q <= auto_reload_d;
         load_q        <= load_d;
         count_q       <= count_d;
         expired_q     <= expired_d;
         prescale_q    <= prescale_d;
         pcnt_q        <= pcnt_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign irq         = expired_q & irq_en_q;

endmodule

// File: tb/tb_iomem_timer.sv
// Bench for iomem_timer: bus accesses are scored by a monitor that expects
// each acknowledge on the cycle right after the request is presented.
module tb_iomem_timer;

   localparam logic [31:0] BASE    = 32'h0300_0000;
   localparam logic [31:0] A_CTRL  = BASE + 32'h00;
   localparam logic [31:0] A_LOAD  = BASE + 32'h04;
   localparam logic [31:0] A_COUNT = BASE + 32'h08;
   localparam logic [31:0] A_STAT  = BASE + 32'h0C;
   localparam logic [31:0] A_PRE   = BASE + 32'h10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic        ready;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        irq;

   iomem_timer #(.BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (valid),
      .iomem_ready (ready),
      .iomem_wstrb (wstrb),
      .iomem_addr  (addr),
      .iomem_wdata (wdata),
      .iomem_rdata (rdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
      bit          chk;
      int unsigned due;
   } sb_t;

   sb_t         sb_q[$];
   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   bit          mon_due;
   sb_t         mon_e;

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle: ready must match the scoreboard head's due cycle
   always @(negedge clk) begin
      mon_due = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      expect_eq("ready", {31'b0, ready}, {31'b0, mon_due});
      if (mon_due) begin
         mon_e = sb_q.pop_front();
         if (mon_e.chk) expect_eq(mon_e.tag, rdata, mon_e.exp);
      end else begin
         expect_eq("rdata_idle", rdata, 32'h0);
      end
   end

   task automatic sb_push(input string tag, input logic [31:0] exp, input bit chk);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      e.chk = chk;
      e.due = cyc + 1;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns 1ns after the accepting edge; caller must allow an idle cycle
   task automatic bus_go(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic [31:0] exp, input bit chk, input string tag);
      valid = 1'b1;
      addr  = a;
      wstrb = s;
      wdata = d;
      sb_push(tag, exp, chk);
      @(posedge clk);
      #1;
      valid = 1'b0;
      wstrb = 4'h0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      bus_go(a, s, d, 32'h0, 1'b0, "wr");
      idle(1);
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus_go(a, 4'h0, 32'h0, exp, 1'b1, tag);
      idle(1);
   endtask

   initial begin
      // Reset, then every offset reads zero
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) bus_rd(BASE + 32'(4 * i), 32'h0, $sformatf("rst_rd%0d", i));
      expect_eq("rst_irq", {31'b0, irq}, 32'h0);

      // Byte lanes
      bus_wr(A_LOAD, 4'b0101, 32'hA5A5_A5A5);
      bus_rd(A_LOAD, 32'h00A5_00A5, "load_strb");
      bus_wr(A_PRE, 4'hF, 32'hFFFF_1234);
      bus_rd(A_PRE, 32'h0000_1234, "prescale_w");

      // Out-of-window requests are ignored
      valid = 1'b1;
      wstrb = 4'hF;
      wdata = 32'hFFFF_FFFF;
      addr  = BASE + 32'h20;
      idle(10);
      addr  = 32'h0200_0004;
      idle(10);
      valid = 1'b0;
      wstrb = 4'h0;
      bus_rd(A_CTRL, 32'h0, "dec_ctrl");
      bus_rd(A_LOAD, 32'h00A5_00A5, "dec_load");

      // Unused offset held valid for three cycles: ready 0,1,0
      bus_wr(BASE + 32'h18, 4'hF, 32'hFFFF_FFFF);
      valid = 1'b1;
      addr  = BASE + 32'h18;
      expect_eq("hold_t0", {31'b0, ready}, 32'h0);
      sb_push("hold_rdata", 32'h0, 1'b1);
      idle(2);
      valid = 1'b0;
      idle(1);

      // One-shot: N=4, P=3 expires 20 edges after enable
      bus_wr(A_PRE, 4'hF, 32'd3);
      bus_wr(A_COUNT, 4'hF, 32'd4);
      bus_go(A_CTRL, 4'hF, 32'h3, 32'h0, 1'b0, "ctrl_os");
      idle(19);
      expect_eq("os_irq_e19", {31'b0, irq}, 32'h0);
      idle(1);
      expect_eq("os_irq_e20", {31'b0, irq}, 32'h1);
      idle(1);
      bus_rd(A_STAT, 32'h1, "os_stat");
      bus_rd(A_CTRL, 32'h2, "os_ctrl");
      bus_rd(A_COUNT, 32'h0, "os_count");
      idle(100);
      bus_rd(A_CTRL, 32'h2, "os_ctrl_late");
      bus_rd(A_COUNT, 32'h0, "os_count_late");
      expect_eq("os_irq_late", {31'b0, irq}, 32'h1);

      // Auto-reload, LOAD=2, P=0
      bus_wr(A_PRE, 4'hF, 32'd0);
      bus_wr(A_LOAD, 4'hF, 32'd2);
      bus_wr(A_COUNT, 4'hF, 32'd2);
      bus_wr(A_STAT, 4'hF, 32'h0);
      expect_eq("w0_no_clear", {31'b0, irq}, 32'h1);
      bus_wr(A_STAT, 4'h1, 32'h1);
      expect_eq("w1c_clear", {31'b0, irq}, 32'h0);
      bus_go(A_CTRL, 4'hF, 32'h7, 32'h0, 1'b0, "ctrl_ar");
      expect_eq("ar_e0", {31'b0, irq}, 32'h0);
      idle(1);
      expect_eq("ar_e1", {31'b0, irq}, 32'h0);
      idle(1);
      expect_eq("ar_e2", {31'b0, irq}, 32'h0);
      idle(1);
      expect_eq("ar_e3", {31'b0, irq}, 32'h1);
      bus_go(A_STAT, 4'h1, 32'h1, 32'h1, 1'b1, "w1c_e4_rd");
      expect_eq("ar_e4_cleared", {31'b0, irq}, 32'h0);
      idle(1);
      expect_eq("ar_e5", {31'b0, irq}, 32'h0);
      idle(1);
      expect_eq("ar_e6", {31'b0, irq}, 32'h1);
      idle(2);
      bus_go(A_STAT, 4'h1, 32'h1, 32'h1, 1'b1, "w1c_e9_rd");
      expect_eq("ar_e9_set_wins", {31'b0, irq}, 32'h1);
      idle(1);
      expect_eq("ar_e10", {31'b0, irq}, 32'h1);

      // COUNT write beats the tick; then reset mid-count with valid high
      bus_wr(A_COUNT, 4'hF, 32'd100);
      bus_wr(A_CTRL, 4'hF, 32'h3);
      bus_rd(A_COUNT, 32'd97, "cnt_wr_prio");
      idle(6);
      expect_eq("pre_rst_irq", {31'b0, irq}, 32'h1);
      reset = 1'b1;
      valid = 1'b1;
      addr  = A_COUNT;
      wstrb = 4'h0;
      idle(1);
      expect_eq("mid_rst_irq", {31'b0, irq}, 32'h0);
      expect_eq("mid_rst_rdata", rdata, 32'h0);
      reset = 1'b0;
      valid = 1'b0;
      for (int i = 0; i < 8; i++) bus_rd(BASE + 32'(4 * i), 32'h0, $sformatf("post_rst_rd%0d", i));
      expect_eq("post_rst_irq", {31'b0, irq}, 32'h0);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped countdown timer that acts as a responder on the SoC's external `iomem_*` bus, the port the SoC drives for every address at or above `0x0200_0000` not claimed internally. It decodes a 32-byte register window and returns a registered single-cycle `iomem_ready`. It provides a prescaled 32-bit down-counter with one-shot or auto-reload modes and a level interrupt, intended for the SoC's `irq_5` input.

## Interface
- `BASE_ADDR`, default `32'h0300_0000`: window base; must be 32-byte aligned.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iomem_valid`  in  1  request valid; held by the initiator until `iomem_ready`.
- `iomem_ready`  out  1  single-cycle acknowledge; asserted only for in-window accesses.
- `iomem_wstrb`  in  4  byte write strobes; `0` means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid only while `iomem_ready` is high, otherwise 0.
- `irq`  out  1  level interrupt, equal to `STATUS.expired & CTRL.irq_en`.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:5] == BASE_ADDR[31:5]`. Register offset is `iomem_addr[4:2]`. Bits `[1:0]` are ignored.
- Accept: a transaction is accepted in any cycle with `sel && !iomem_ready`.
  - Writes are applied at that clock edge, per byte lane according to `iomem_wstrb`.
  - `iomem_rdata` is registered from the pre-write register value at the same edge.
- Registers (all reset to 0):
  - `0x00 CTRL`: bit0 `enable`, bit1 `irq_en`, bit2 `auto_reload`; other bits read 0.
  - `0x04 LOAD`: 32-bit reload value.
  - `0x08 COUNT`: current count; a write loads the counter directly.
  - `0x0C STATUS`: bit0 `expired`; writing 1 to bit0 (lane 0) clears it; writing 0 has no effect.
  - `0x10 PRESCALE`: 16 bits in `[15:0]`; upper bits read 0.
  - Offsets `0x14`–`0x1C`: read 0, writes ignored, still acknowledged.
- Prescaler:
  - Internal 16-bit `pcnt`.
  - While `enable` is set: if `pcnt == PRESCALE`, a tick is generated and `pcnt` returns to 0; otherwise `pcnt` increments.
  - `pcnt` is held at 0 while `enable` is clear.
- On each tick:
  - If `COUNT != 0`, `COUNT` decrements.
  - If `COUNT == 0`, the timer expires: `expired` is set. With `auto_reload`, `COUNT` takes `LOAD`. Without it, `enable` is cleared (one-shot) and `COUNT` stays 0.
- Collision priorities, same cycle:
  - A bus write to `COUNT` beats the tick decrement or reload.
  - An expiry set beats a W1C clear of `expired`.
  - A bus write to `CTRL.enable` beats a one-shot auto-clear.
- Reset mid-transaction: all registers, `pcnt`, `iomem_ready` and `iomem_rdata` return to 0. A pending request is dropped; the initiator re-presents it after reset.

## Timing
- Reset values: `iomem_ready=0`, `iomem_rdata=0`, `irq=0`.
- Access latency is exactly 1 cycle.
  - `iomem_valid` and `sel` are high in cycle T; `iomem_ready` is high in T+1 only.
  - `iomem_ready` is forced low in T+2 even if `valid` remains high, so back-to-back accesses take 2 cycles each.
- Out-of-window or idle: `iomem_ready` and `iomem_rdata` stay 0 and no register changes.
- Expiry timing:
  - Setup: `COUNT=N`, `PRESCALE=P`, then `enable` written 0→1 at edge E.
  - The first tick is at edge E+P+1.
  - `expired` sets at edge E+(N+1)(P+1).
  - `irq` rises in the same cycle (combinational from registers).
- Auto-reload period: (`LOAD`+1)(P+1) cycles between expiries.
- `LOAD=0` with `P=0` and `auto_reload` set: expiry on every cycle; `expired` stays high.

## Test plan
- Reset: hold `reset` for 2 cycles, then read all 8 offsets. Each returns 0 with `iomem_ready` high exactly 1 cycle after `valid`. `irq` stays 0.
- Byte strobes: write `0xA5A5A5A5` to `LOAD` with `wstrb=4'b0101`, then read `LOAD` → `0x00A500A5`. Write `PRESCALE=0xFFFF_1234` → read `0x0000_1234`.
- One-shot: `PRESCALE=3`, `COUNT=4`, `CTRL=0x3` at edge E. `expired` and `irq` go high at E+20. `CTRL` reads `0x2`, `COUNT` reads 0, and no further change occurs for 100 cycles.
- Auto-reload with W1C: `LOAD=2`, `P=0`, `CTRL=0x7`. Expiries occur every 3 cycles. A W1C to `STATUS` issued on an expiry cycle leaves `expired=1`; one issued on a non-expiry cycle clears it.
- Decode: hold `valid` for 10 cycles at `BASE_ADDR+0x20` and at `0x0200_0004`. `iomem_ready` stays 0 and no register changes. Hold `valid` at `BASE_ADDR+0x18` for 3 cycles: `ready` pattern is 0,1,0 and `rdata` is 0.
- Reset mid-count: `COUNT=100`, enabled; assert `reset` at cycle 10 with `valid` high. Next cycle all registers read 0 and `irq=0`.
